cpu_sequencer: RTL and testbench

Multi-cycle control sequencer for the RV32I CPU datapath. It steps each instruction through fetch, decode, execute, memory and writeback.
- Generates the enable strobes for the instruction register, PC, register file and data memory.
- Handles variable-latency memory handshakes, run/single-step control, halt detection on the self-loop `jal x0,0`, and the cycle and retired-instruction counters.
- Sits in `cpu` between the instruction/data memories and the execution unit, and replaces the free-running fetch/execute alternation.

---
 rtl/cpu_seq_pkg.sv | 39 +++
 rtl/cpu_sequencer_wait_timer.sv | 31 +++
 rtl/cpu_sequencer.sv | 158 +++++++++++++++
 tb/tb_cpu_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the multi-cycle RV32I control sequencer:
// state encodings, RV32I major opcodes and default parameter values.
package cpu_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEM       = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_STOP      = 3'd6
    } seq_state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    // jal x0,0 : a jump onto itself, used as the program-end marker
    localparam logic [31:0] HALT_INSTR_DEFAULT  = 32'h0000006F;
    localparam int unsigned MEM_TIMEOUT_DEFAULT = 255;

    // True for every major opcode the datapath can execute
    function automatic logic opcode_supported(input logic [6:0] opc);
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
            OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP, OPC_FENCE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cpu_sequencer_wait_timer.sv
// Loadable 8-bit wait counter for memory handshakes. It counts the cycles
// spent waiting for a ready and flags the last cycle allowed before a
// bus error (the cycle whose increment would reach LIMIT).
module seq_wait_timer #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam logic [8:0] LIMIT_W = 9'(LIMIT);

    logic [7:0] count;

    // Count waiting cycles; cleared whenever no handshake is in progress
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 8'd0;
        end else if (clear) begin
            count <= 8'd0;
        end else if (inc) begin
            count <= count + 8'd1;
        end
    end

    assign expired = ({1'b0, count} + 9'd1) == LIMIT_W;

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer for the RV32I datapath. Walks each
// instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK, produces the
// IR/PC/RF/DMEM strobes, and stops on halt, illegal opcode or bus timeout.
module cpu_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
    parameter logic [31:0] HALT_INSTR  = HALT_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        step_req,
    input  logic [31:0] instr,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        imem_req,
    output logic        ir_we,
    output logic        pc_we,
    output logic        rf_we,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [2:0]  state,
    output logic        halted,
    output logic        bus_error,
    output logic        illegal,
    output logic [31:0] cycle_count,
    output logic [31:0] retired_count
);

    seq_state_t state_q;
    logic [6:0] opc;
    logic       is_load;
    logic       is_store;
    logic       is_no_wb;
    logic       waiting;
    logic       tmr_clear;
    logic       tmr_inc;
    logic       tmr_expired;
    logic       commit;
    seq_state_t after_commit;

    assign opc      = instr[6:0];
    assign is_load  = (opc == OPC_LOAD);
    assign is_store = (opc == OPC_STORE);
    assign is_no_wb = (opc == OPC_BRANCH) || (opc == OPC_FENCE);

    // After retiring, keep going while run is held, otherwise park in IDLE
    assign after_commit = run ? ST_FETCH : ST_IDLE;

    // The timer only runs while a memory handshake is outstanding
    assign waiting   = (state_q == ST_FETCH) || (state_q == ST_MEM);
    assign tmr_clear = !waiting;
    assign tmr_inc   = ((state_q == ST_FETCH) && !imem_ready) ||
                       ((state_q == ST_MEM) && !dmem_ready);

    seq_wait_timer #(
        .LIMIT(MEM_TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (tmr_clear),
        .inc    (tmr_inc),
        .expired(tmr_expired)
    );

    // Moore outputs straight from the state register
    assign imem_req = (state_q == ST_FETCH);
    assign dmem_req = (state_q == ST_MEM);
    assign dmem_we  = (state_q == ST_MEM) && is_store;
    assign state    = state_q;

    // Single-cycle strobes; commit happens in the last state of an instruction
    always_comb begin
        commit = 1'b0;
        case (state_q)
            ST_EXECUTE:   commit = is_no_wb;
            ST_MEM:       commit = dmem_ready && is_store;
            ST_WRITEBACK: commit = 1'b1;
            default:      commit = 1'b0;
        endcase
        ir_we = (state_q == ST_FETCH) && imem_ready;
        rf_we = (state_q == ST_WRITEBACK);
        pc_we = commit;
    end

    // Sequencer FSM with sticky stop flags and the cycle/retire counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            halted        <= 1'b0;
            bus_error     <= 1'b0;
            illegal       <= 1'b0;
            cycle_count   <= 32'd0;
            retired_count <= 32'd0;
        end else begin
            if (state_q != ST_STOP) begin
                cycle_count <= cycle_count + 32'd1;
            end
            if (commit) begin
                retired_count <= retired_count + 32'd1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (run || step_req) begin
                        state_q <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (imem_ready) begin
                        state_q <= ST_DECODE;
                    end else if (tmr_expired) begin
                        state_q   <= ST_STOP;
                        bus_error <= 1'b1;
                    end
                end
                ST_DECODE: begin
                    if (instr == HALT_INSTR) begin
                        state_q <= ST_STOP;
                        halted  <= 1'b1;
                    end else if (!opcode_supported(opc)) begin
                        state_q <= ST_STOP;
                        illegal <= 1'b1;
                    end else begin
                        state_q <= ST_EXECUTE;
                    end
                end
                ST_EXECUTE: begin
                    if (is_load || is_store) begin
                        state_q <= ST_MEM;
                    end else if (is_no_wb) begin
                        state_q <= after_commit;
                    end else begin
                        state_q <= ST_WRITEBACK;
                    end
                end
                ST_MEM: begin
                    if (dmem_ready) begin
                        state_q <= is_load ? ST_WRITEBACK : after_commit;
                    end else if (tmr_expired) begin
                        state_q   <= ST_STOP;
                        bus_error <= 1'b1;
                    end
                end
                ST_WRITEBACK: begin
                    state_q <= after_commit;
                end
                ST_STOP: begin
                    state_q <= ST_STOP;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed testbench for cpu_sequencer with a small instruction/data
// memory model whose ready latency is programmable per test.
module tb_cpu_sequencer;

    localparam logic [31:0] I_ADDI1 = 32'h00100093; // addi x1,x0,1
    localparam logic [31:0] I_ADDI2 = 32'h00208113; // addi x2,x1,2
    localparam logic [31:0] I_ADDI3 = 32'h00310193; // addi x3,x2,3
    localparam logic [31:0] I_HALT  = 32'h0000006F; // jal x0,0
    localparam logic [31:0] I_LW    = 32'h00002083; // lw x1,0(x0)
    localparam logic [31:0] I_SW    = 32'h00102023; // sw x1,0(x0)
    localparam logic [31:0] I_SYS   = 32'h00000073; // ecall (SYSTEM)

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        step_req;
    logic [31:0] instr;
    logic        imem_ready;
    logic        dmem_ready;
    logic        imem_req;
    logic        ir_we;
    logic        pc_we;
    logic        rf_we;
    logic        dmem_req;
    logic        dmem_we;
    logic [2:0]  state;
    logic        halted;
    logic        bus_error;
    logic        illegal;
    logic [31:0] cycle_count;
    logic [31:0] retired_count;

    cpu_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .step_req     (step_req),
        .instr        (instr),
        .imem_ready   (imem_ready),
        .dmem_ready   (dmem_ready),
        .imem_req     (imem_req),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .rf_we        (rf_we),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .state        (state),
        .halted       (halted),
        .bus_error    (bus_error),
        .illegal      (illegal),
        .cycle_count  (cycle_count),
        .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Memory model: program ROM indexed by a PC that follows pc_we, and
    // ready signals that rise after a programmable number of wait cycles.
    logic [31:0] prog [0:7];
    logic [31:0] pc_idx;
    int          imem_dly;
    int          dmem_dly;
    int          icnt;
    int          mcnt;

    assign imem_ready = imem_req && (icnt >= imem_dly);
    assign dmem_ready = dmem_req && (mcnt >= dmem_dly);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_idx <= 32'd0;
            instr  <= 32'd0;
            icnt   <= 0;
            mcnt   <= 0;
        end else begin
            if (ir_we) instr <= prog[pc_idx[2:0]];
            if (pc_we) pc_idx <= pc_idx + 32'd1;
            icnt <= (imem_req && !imem_ready) ? icnt + 1 : 0;
            mcnt <= (dmem_req && !dmem_ready) ? mcnt + 1 : 0;
        end
    end

    // Per-run event log; cycle 0 is the first cycle after reset release
    int cur_cyc;
    int n_ir, n_pc, n_rf, n_imem, n_dmem;
    int pc_cyc[$];
    int first_stop, rdy_cyc, rf_cyc;

    task automatic log_clear();
        n_ir = 0; n_pc = 0; n_rf = 0; n_imem = 0; n_dmem = 0;
        pc_cyc.delete();
        first_stop = -1; rdy_cyc = -1; rf_cyc = -1;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            #1;
            if (ir_we) n_ir++;
            if (pc_we) begin n_pc++; pc_cyc.push_back(cur_cyc); end
            if (rf_we) begin n_rf++; rf_cyc = cur_cyc; end
            if (imem_req) n_imem++;
            if (dmem_req) n_dmem++;
            if (dmem_ready && rdy_cyc < 0) rdy_cyc = cur_cyc;
            if (state == 3'd6 && first_stop < 0) first_stop = cur_cyc;
            cur_cyc++;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset   = 1'b0;
        cur_cyc = 0;
        log_clear();
    endtask

    function automatic int pc_at(input int k);
        return (pc_cyc.size() > k) ? pc_cyc[k] : -1;
    endfunction

    initial begin
        reset    = 1'b1;
        run      = 1'b0;
        step_req = 1'b0;
        imem_dly = 0;
        dmem_dly = 0;
        for (int i = 0; i < 8; i++) prog[i] = I_HALT;

        // Straight-line ALU program ending on the halt self-loop
        prog[0] = I_ADDI1; prog[1] = I_ADDI2; prog[2] = I_ADDI3; prog[3] = I_HALT;
        run = 1'b1;
        do_reset();
        #1;
        check("rst_state", {29'd0, state}, 32'd0);
        check("rst_cycles", cycle_count, 32'd0);
        check("rst_retired", retired_count, 32'd0);
        check("rst_flags", {29'd0, halted, bus_error, illegal}, 32'd0);
        run_cycles(20);
        check("alu_pcwe_n", n_pc, 3);
        check("alu_pcwe_0", pc_at(0), 4);
        check("alu_pcwe_1", pc_at(1), 8);
        check("alu_pcwe_2", pc_at(2), 12);
        check("alu_irwe_n", n_ir, 4);
        check("alu_rfwe_n", n_rf, 3);
        check("alu_stop_cyc", first_stop, 15);
        check("alu_halted", {31'd0, halted}, 32'd1);
        check("alu_state", {29'd0, state}, 32'd6);
        check("alu_retired", retired_count, 32'd3);
        check("alu_cycles_frozen", cycle_count, 32'd15);
        check("alu_pc_on_halt", pc_idx, 32'd3);
        check("alu_other_flags", {30'd0, bus_error, illegal}, 32'd0);

        // Single step of a load with data memory ready after 3 wait cycles
        for (int i = 0; i < 8; i++) prog[i] = I_ADDI1;
        prog[0] = I_LW;
        run = 1'b0; step_req = 1'b1; dmem_dly = 3;
        do_reset();
        run_cycles(1);
        step_req = 1'b0;
        run_cycles(13);
        check("ld_dmemreq_n", n_dmem, 4);
        check("ld_ready_cyc", rdy_cyc, 7);
        check("ld_rfwe_cyc", rf_cyc, 8);
        check("ld_rfwe_n", n_rf, 1);
        check("ld_pcwe_cyc", pc_at(0), 8);
        check("ld_pcwe_n", n_pc, 1);
        check("ld_imemreq_n", n_imem, 1);
        check("ld_state", {29'd0, state}, 32'd0);
        check("ld_retired", retired_count, 32'd1);
        check("ld_cycles", cycle_count, 32'd14);

        // Instruction memory never ready: bus error after 255 fetch cycles
        prog[0] = I_ADDI1;
        run = 1'b1; dmem_dly = 0; imem_dly = 1000;
        do_reset();
        run_cycles(262);
        check("to_imemreq_n", n_imem, 255);
        check("to_irwe_n", n_ir, 0);
        check("to_stop_cyc", first_stop, 256);
        check("to_bus_error", {31'd0, bus_error}, 32'd1);
        check("to_state", {29'd0, state}, 32'd6);
        check("to_halted", {31'd0, halted}, 32'd0);
        check("to_pcwe_n", n_pc, 0);
        check("to_cycles", cycle_count, 32'd256);

        // Ready on the last permitted fetch cycle completes the access
        prog[0] = I_HALT;
        imem_dly = 254;
        do_reset();
        run_cycles(262);
        check("rw_irwe_n", n_ir, 1);
        check("rw_bus_error", {31'd0, bus_error}, 32'd0);
        check("rw_halted", {31'd0, halted}, 32'd1);
        check("rw_stop_cyc", first_stop, 257);

        // Unsupported SYSTEM opcode stops from DECODE
        prog[0] = I_SYS;
        imem_dly = 0;
        do_reset();
        run_cycles(8);
        check("ill_flag", {31'd0, illegal}, 32'd1);
        check("ill_halted", {31'd0, halted}, 32'd0);
        check("ill_pcwe_n", n_pc, 0);
        check("ill_retired", retired_count, 32'd0);
        check("ill_stop_cyc", first_stop, 3);

        // Dropping run mid-instruction finishes it and then idles
        prog[0] = I_ADDI1; prog[1] = I_ADDI2;
        run = 1'b1;
        do_reset();
        run_cycles(2);
        run = 1'b0;
        run_cycles(8);
        check("rc_pcwe_n", n_pc, 1);
        check("rc_pcwe_cyc", pc_at(0), 4);
        check("rc_imemreq_n", n_imem, 1);
        check("rc_state", {29'd0, state}, 32'd0);
        check("rc_retired", retired_count, 32'd1);

        // Asynchronous reset while a store waits in MEM
        prog[0] = I_SW;
        run = 1'b1; dmem_dly = 1000;
        do_reset();
        run_cycles(6);
        #1;
        check("ar_in_mem", {29'd0, state}, 32'd4);
        check("ar_dmem_we", {30'd0, dmem_req, dmem_we}, 32'd3);
        #1;
        reset = 1'b1;
        #1;
        check("ar_state", {29'd0, state}, 32'd0);
        check("ar_strobes", {27'd0, dmem_req, dmem_we, pc_we, rf_we, ir_we}, 32'd0);
        check("ar_cycles", cycle_count, 32'd0);
        check("ar_retired", retired_count, 32'd0);
        @(negedge clk);
        run = 1'b0; dmem_dly = 0; step_req = 1'b1;
        reset = 1'b0;
        cur_cyc = 0;
        log_clear();
        run_cycles(1);
        step_req = 1'b0;
        run_cycles(7);
        check("ar_st_pcwe_cyc", pc_at(0), 4);
        check("ar_st_pcwe_n", n_pc, 1);
        check("ar_st_dmemreq_n", n_dmem, 1);
        check("ar_st_state", {29'd0, state}, 32'd0);
        check("ar_st_retired", retired_count, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
